// File: rtl/cla_seq_controller.sv
// cla_seq_controller
//   Adds or subtracts two WIDTH-bit operands by time-sharing an external,
//   purely combinational 4-bit carry-lookahead adder slice. One nibble is
//   processed per clock, least-significant first. The carry is chained
//   between nibbles through an internal register.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_a, in_b, in_sub, in_cin are
//                         sampled only at the accepting edge
//   add_a/add_b/add_cin   operand nibbles and carry driven to the adder slice
//   add_sum/add_cout      combinational response of the adder slice
//   out_valid/out_ready   result handshake
//   out_sum, out_carry    result and final carry (sub: 1 = no borrow)
//   out_ovf, out_zero     signed overflow and zero flags
//   busy                  controller is not idle
module cla_seq_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;

  // Result/flag registers presented on out_*. They load only at the edge
  // that enters DONE, so they stay stable under backpressure and keep their
  // value after the handshake while the working result register is cleared.
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             oc_q, oc_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             last_nib;
  logic [IW+1:0]    nib_base;

  assign last_nib = (idx_q == IW'(N - 1));
  assign nib_base = {idx_q, 2'b00};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = ~rst;
      RUN: begin
        busy    = 1'b1;
        add_a   = opa_q[nib_base +: 4];
        add_b   = opb_q[nib_base +: 4];
        add_cin = carry_q;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_sum   = sum_q;
  assign out_carry = oc_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  // Datapath next-value logic
  always_comb begin
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    oc_d    = oc_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = in_a;
          // Subtraction is A + ~B + 1; the +1 enters through the carry.
          opb_d   = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        res_d[nib_base +: 4] = add_sum;
        carry_d              = add_cout;
        if (last_nib) begin
          // Flags are taken from the completed result including the
          // nibble written this cycle.
          sum_d  = res_d;
          oc_d   = add_cout;
          ovf_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                   (res_d[WIDTH-1] != opa_q[WIDTH-1]);
          zero_d = (res_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      oc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      oc_q    <= oc_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: doc/cla_seq_controller.md
Name: cla_seq_controller

Overview:
- Sequences a shared 4-bit carry-lookahead adder slice to add or subtract WIDTH-bit operands, one nibble per clock, least-significant nibble first.
- The slice is external and purely combinational. This block drives its operand and carry-in ports, registers its sum and carry-out, and chains the carry between nibbles.
- Upstream and downstream use valid/ready handshakes.
- Results carry the flags carry, signed overflow and zero.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 is derived: nibble count, equal to run cycles per operation.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A - B, 0 = A + B
- in_cin  in  1  carry-in for add; ignored for sub
- add_a  out  4  nibble of A to adder slice
- add_b  out  4  nibble of B (or ~B) to adder slice
- add_cin  out  1  carry-in to adder slice
- add_sum  in  4  adder slice sum (combinational from add_a/add_b/add_cin)
- add_cout  in  1  adder slice carry-out
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_carry  out  1  final carry-out; for sub, 1 = no borrow
- out_ovf  out  1  two's-complement signed overflow
- out_zero  out  1  out_sum == 0
- busy  out  1  state != IDLE

Behaviour:

Reset:
- rst asserted asynchronously forces state IDLE, nibble index 0, and all operand, result, carry and flag registers to 0.
- out_valid is 0 and add_a/add_b/add_cin are 0 while rst is asserted.
- in_ready is forced 0 while rst is high.
- Reset mid-operation aborts silently; no result is produced.

FSM states: IDLE, RUN, DONE.

IDLE:
- in_ready = 1 (rst low).
- On in_valid & in_ready at a rising edge:
  - latch A into opA.
  - latch B into opB, or ~B if in_sub.
  - carry reg = in_sub ? 1 : in_cin.
  - idx = 0; clear result reg; go to RUN.

RUN:
- in_ready = 0.
- Adder drive is combinational from registers: add_a = opA[4*idx+3:4*idx], add_b = opB[4*idx+3:4*idx], add_cin = carry reg.
- Each edge: result nibble idx <= add_sum; carry reg <= add_cout; idx increments.
- At the edge where idx == N-1, go to DONE instead of incrementing.

DONE:
- out_valid = 1.
- out_sum = result reg; out_carry = carry reg.
- out_ovf = (opA[MSB] == opB[MSB]) & (result[MSB] != opA[MSB]), using the latched (possibly inverted) opB.
- out_zero = (result == 0).
- All out_* are held stable while out_valid & !out_ready.
- On out_valid & out_ready go to IDLE. out_valid drops the next cycle; out_sum/flags retain their last value until the next DONE.

Outside RUN: add_a, add_b, add_cin are driven 0.

Timing:
- Latency: out_valid rises exactly N cycles after the accepting edge.
- Throughput: one operation per N+2 cycles minimum (accept, N run, handshake).

Handshake and boundaries:
- in_valid in RUN/DONE is ignored; the request must be held by upstream until in_ready.
- Inputs in_a/in_b/in_sub/in_cin are sampled only at the accepting edge; later changes have no effect.
- Carry is wrapped only through the carry reg. No carry from the previous operation leaks into the next: the carry reg is reloaded at accept.
- WIDTH = 4: single RUN cycle, same rules.

Test Plan:
WIDTH = 16 throughout.
1. Add 0x1234 + 0x0FCD, cin 0 -> out_sum 0x2201, carry 0, ovf 0, zero 0. out_valid exactly 4 cycles after accept. add_a monitored as 4, 3, 2, 1 and add_b as D, C, F, 0 on successive RUN cycles.
2. Add 0xFFFF + 0x0001, cin 0 -> out_sum 0x0000, carry 1, zero 1, ovf 0. Then 0x7FFF + 0x0000, cin 1 -> 0x8000, ovf 1, carry 0.
3. Sub 0x0005 - 0x0007 -> 0xFFFE, carry 0, ovf 0. Sub 0x8000 - 0x0001 -> 0x7FFF, ovf 1, carry 1. Sub 0x1234 - 0x1234 -> 0x0000, zero 1, carry 1 (in_cin = 1 has no effect).
4. Backpressure: hold out_ready 0 for 5 cycles in DONE while toggling in_valid/in_a -> out_* stable, in_ready 0, nothing accepted. Raise out_ready -> IDLE next cycle, in_ready 1. A new request then completes correctly with no carry carried over.
5. Operand change: alter in_a/in_b during RUN -> result matches values latched at accept.
6. Reset mid-RUN after 2 nibbles -> out_valid 0 and add_* 0 immediately, in_ready 0 during reset and 1 after release. The next request 0x00FF + 0x0001 -> 0x0100 with correct latency.
